// File: rtl/modmul_iter.sv
// modmul_iter: iterative (X*Y) mod M, retiring BPC multiplier bits per clock, MSB first.
// Define MODMUL_RANGE_CHECK_EN to reject M==0 or Y>=M at start with a one-cycle err completion.
module modmul_iter #(
  parameter int WIDTH = 256,
  parameter int BPC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic [WIDTH-1:0] M,
  output logic [WIDTH-1:0] Q,
  output logic             done,
  output logic             ready,
  output logic             busy,
  output logic             err
);
  localparam int N = WIDTH / BPC;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic {IDLE, CALC} state_t;
  state_t state;
  logic [WIDTH-1:0] xr, yr, mr;
  logic [WIDTH+1:0] r;
  logic [CW-1:0] count;
  logic [BPC:0][WIDTH+1:0] t;
  logic bad;
  assign ready = state == IDLE;
  assign busy = state == CALC;
  assign t[0] = r;
  // 2R + Y < 3M, so two conditional subtractions restore R < M
  for (genvar i = 0; i < BPC; i++) begin : g_step
    logic [WIDTH+1:0] s, u;
    assign s = (t[i] << 1) + (xr[WIDTH-1-i] ? {2'b0, yr} : '0);
    assign u = s >= {2'b0, mr} ? s - {2'b0, mr} : s;
    assign t[i+1] = u >= {2'b0, mr} ? u - {2'b0, mr} : u;
  end
`ifdef MODMUL_RANGE_CHECK_EN
  assign bad = M == '0 || Y >= M;
  always_ff @(posedge clk)
    if (!rst) err <= 1'b0;
    else if (ready && start) err <= bad;
`else
  assign bad = 1'b0;
  assign err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      Q <= '0;
      done <= 1'b0;
      r <= '0;
      count <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start && bad) begin
          done <= 1'b1;
          Q <= '0;
        end else if (start) begin
          xr <= X;
          yr <= Y;
          mr <= M;
          r <= '0;
          count <= CW'(N - 1);
          state <= CALC;
        end
      end else begin
        r <= t[BPC];
        xr <= xr << BPC;
        if (count == '0) begin
          Q <= t[BPC][WIDTH-1:0];
          done <= 1'b1;
          state <= IDLE;
        end else count <= count - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_modmul_iter.sv
// tb_modmul_iter: scoreboard bench for an 8-bit/BPC=2 and a 256-bit/BPC=1 modmul_iter against a % reference.
module tb_modmul_iter;
  localparam int NA = 4;
  localparam int NB = 256;
  localparam logic [255:0] P25519 = (256'd1 << 255) - 256'd19;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic a_start = 0;
  logic [7:0] a_x = 0, a_y = 0, a_m = 1, a_q;
  logic a_done, a_ready, a_busy, a_err;
  logic b_start = 0;
  logic [255:0] b_x = 0, b_y = 0, b_m = 1, b_q;
  logic b_done, b_ready, b_busy, b_err;
  modmul_iter #(.WIDTH(8), .BPC(2)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .X(a_x), .Y(a_y), .M(a_m),
    .Q(a_q), .done(a_done), .ready(a_ready), .busy(a_busy), .err(a_err));
  modmul_iter #(.WIDTH(256), .BPC(1)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .X(b_x), .Y(b_y), .M(b_m),
    .Q(b_q), .done(b_done), .ready(b_ready), .busy(b_busy), .err(b_err));
  typedef struct {
    logic [255:0] q;
    logic e;
    logic chk;
    int due;
  } exp_t;
  exp_t qa[$], qb[$];
  exp_t ea, eb;
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // Expected completion: result, error flag and the cycle count at which done must be seen
  function automatic exp_t model(input logic [255:0] x, input logic [255:0] y, input logic [255:0] m, input int n);
    exp_t e;
    logic [511:0] p;
    logic ok;
    ok = m != 0 && y < m;
    e.e = 1'b0;
    e.chk = ok;
    e.q = '0;
    e.due = cyc + n + 1;
    if (ok) begin
      p = {256'd0, x} * {256'd0, y};
      p = p % {256'd0, m};
      e.q = p[255:0];
    end
`ifdef MODMUL_RANGE_CHECK_EN
    if (!ok) begin
      e.e = 1'b1;
      e.chk = 1'b1;
      e.due = cyc + 1;
    end
`endif
    return e;
  endfunction
  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction
  task automatic step_a(input logic s, input logic [7:0] x, input logic [7:0] y, input logic [7:0] m);
    a_start = s; a_x = x; a_y = y; a_m = m;
    if (s && a_ready && rst) qa.push_back(model({248'd0, x}, {248'd0, y}, {248'd0, m}, NA));
    @(posedge clk); #1;
  endtask
  task automatic step_b(input logic s, input logic [255:0] x, input logic [255:0] y, input logic [255:0] m);
    b_start = s; b_x = x; b_y = y; b_m = m;
    if (s && b_ready && rst) qb.push_back(model(x, y, m, NB));
    @(posedge clk); #1;
  endtask
  task automatic op_a(input logic [7:0] x, input logic [7:0] y, input logic [7:0] m);
    int k = 0;
    while (!a_ready && k < 50) begin step_a(0, 0, 0, 1); k++; end
    chk("a_ready_wait", a_ready, 1);
    step_a(1, x, y, m);
    a_start = 0;
  endtask
  task automatic op_b(input logic [255:0] x, input logic [255:0] y, input logic [255:0] m);
    int k = 0;
    while (!b_ready && k < 600) begin step_b(0, 0, 0, 1); k++; end
    chk("b_ready_wait", b_ready, 1);
    step_b(1, x, y, m);
    b_start = 0;
  endtask
  always @(negedge clk) if (rst) begin
    if (a_done) begin
      if (qa.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL a_spurious_done: got done=1 expected no completion (q=%0h)", a_q);
      end else begin
        ea = qa.pop_front();
        if (ea.chk) chk("a_q", {248'd0, a_q}, ea.q);
        chk("a_err", {255'd0, a_err}, {255'd0, ea.e});
        chk("a_latency", cyc, ea.due);
      end
    end
    if (b_done) begin
      if (qb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL b_spurious_done: got done=1 expected no completion (q=%0h)", b_q);
      end else begin
        eb = qb.pop_front();
        if (eb.chk) chk("b_q", b_q, eb.q);
        chk("b_err", {255'd0, b_err}, {255'd0, eb.e});
        chk("b_latency", cyc, eb.due);
      end
    end
  end
  initial begin
    logic [7:0] m8, y8;
    logic [255:0] m, y;
    int k;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_q", a_q, 0);
    chk("rst_a_done", a_done, 0);
    chk("rst_a_err", a_err, 0);
    chk("rst_a_ready", a_ready, 1);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_b_ready", b_ready, 1);
    chk("rst_b_q", b_q, 0);
    rst = 1;
    step_a(0, 0, 0, 1);
    // back-to-back: second start lands in the done cycle
    step_a(1, 200, 150, 251);
    chk("a_busy_after_start", a_busy, 1);
    chk("a_ready_after_start", a_ready, 0);
    k = 0;
    while (!a_done && k < 20) begin step_a(0, 0, 0, 1); k++; end
    chk("a_done_seen", a_done, 1);
    step_a(1, 0, 7, 13);
    step_a(0, 0, 0, 1);
    // start held/re-driven while busy must be ignored
    op_a(200, 150, 251);
    step_a(1, 200, 150, 251);
    step_a(1, 5, 150, 251);
    step_a(0, 5, 150, 251);
    op_a(0, 99, 200);
    op_a(123, 0, 7);
    op_a(255, 0, 1);
    op_a(255, 254, 255);
    op_a(250, 3, 7);
    op_a(200, 251, 251);
    op_a(200, 5, 0);
    op_a(200, 150, 251);
    // reset mid-calculation discards the operation
    op_a(17, 9, 23);
    repeat (3) step_a(0, 0, 0, 1);
    rst = 0;
    step_a(0, 0, 0, 1);
    chk("abort_busy", a_busy, 0);
    chk("abort_ready", a_ready, 1);
    chk("abort_q", a_q, 0);
    chk("abort_done", a_done, 0);
    qa.delete();
    rst = 1;
    repeat (8) step_a(0, 0, 0, 1);
    // random traffic, start often held across busy periods
    for (int i = 0; i < 300; i++) begin
      m8 = 8'($urandom_range(1, 255));
      y8 = 8'($urandom % m8);
      if ($urandom_range(0, 9) == 0) y8 = 8'($urandom_range(m8, 255));
      if ($urandom_range(0, 19) == 0) m8 = 0;
      step_a($urandom_range(0, 2) != 0, 8'($urandom), y8, m8);
    end
    step_a(0, 0, 0, 1);
    op_b(2, 3, P25519);
    op_b(P25519 - 1, P25519 - 1, P25519);
    for (int i = 0; i < 3; i++) begin
      m = rnd256();
      if (m == 0) m = 1;
      y = rnd256() % m;
      op_b(rnd256(), y, m);
    end
    op_b(rnd256(), 5, 5);
    k = 0;
    while ((qa.size() != 0 || qb.size() != 0) && k < 600) begin step_b(0, 0, 0, 1); k++; end
    chk("drain_pending", qa.size() + qb.size(), 0);
    repeat (3) step_b(0, 0, 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/modmul_iter.md
Name: modmul_iter

Overview:
- Parametrised iterative modular multiplier computing Q = (X*Y) mod M.
- Successor to the fixed 256-bit, fixed-modulus multiplier top.
- Adds: runtime modulus input, configurable operand width, configurable bits retired per cycle, busy/ready status, error flag.
- Sits behind the crypto datapath controller. Driven by a start/done handshake.

Parameters:
- WIDTH, 256: operand, modulus and result width in bits.
- BPC, 1: multiplier bits of X retired per clock. Must divide WIDTH; legal values 1, 2, 4, 8.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only when ready=1.
- X  input  WIDTH  multiplier operand; any value.
- Y  input  WIDTH  multiplicand; must be < M.
- M  input  WIDTH  modulus; must be >= 1.
- Q  output  WIDTH  result; holds until the next completion.
- done  output  1  one-cycle pulse: Q valid, and err valid when the macro is defined.
- ready  output  1  high in IDLE.
- busy  output  1  high in CALC.
- err  output  1  range-check failure; qualified by done.

Behaviour:
- Reset (rst=0 at a clock edge):
  - State=IDLE.
  - Q=0, done=0, err=0, busy=0, ready=1.
  - Internal R=0, count=0.
  - Reset wins over every other event, including mid-CALC: the operation is discarded and no done is issued.
- States: IDLE, CALC.
- IDLE, start=1 at edge E0:
  - Latch X, Y, M into internal registers.
  - R=0, count=WIDTH/BPC-1, state->CALC.
  - Later changes on X, Y, M are ignored.
- CALC, each edge: retire BPC bits of X, MSB first. Each sub-step:
  - T = 2R + x_i*Y, computed at WIDTH+2 bits.
  - If T >= M then T = T - M; then, if T >= M again, T = T - M.
  - R = T. Invariant: R < M, given Y < M.
  - Sub-steps are chained combinationally within the cycle.
- CALC, edge with count=0:
  - Q <= final R, done <= 1, state -> IDLE.
  - Otherwise count decrements.
- Latency: done is high in the cycle after edge E(WIDTH/BPC), i.e. WIDTH/BPC cycles after E0.
  - Default configuration: 256 cycles.
- done is a single-cycle pulse.
  - ready=1 during the done cycle.
  - A start in that cycle is accepted (back-to-back operation, no bubble).
- start while busy=1: ignored, no queueing.
- start held high continuously: a new operation begins on every cycle in which ready=1.
- Boundary results:
  - M=1 gives Q=0.
  - X=0 or Y=0 gives Q=0.
  - X >= M is legal: the result is still X*Y mod M.
- Out-of-range Y (>= M) or M=0 without the macro: Q is undefined, but the FSM must still complete in WIDTH/BPC cycles and return to IDLE.

Optional Feature:
- Macro MODMUL_RANGE_CHECK_EN.
- Defined:
  - At start acceptance, if M==0 or Y>=M: skip CALC.
  - Pulse done with err=1 and Q=0 in the cycle after E0 (latency 1). ready stays 1.
  - Valid operands: err=0 with done.
- Undefined: no comparator logic; err is tied to 0.

Test Plan:
1. WIDTH=8, BPC=1; X=200, Y=150, M=251; pulse start.
   - done exactly 8 cycles after the accepting edge; Q=131; err=0.
   - busy high for 8 cycles.
2. WIDTH=8, BPC=2; same operands.
   - done after 4 cycles; Q=131.
   - Then start in the done cycle with X=0, Y=7, M=13 -> Q=0 after 4 more cycles.
3. WIDTH=256, BPC=1; M=2^255-19.
   - X=2, Y=3 -> Q=6 after 256 cycles.
   - X=M-1, Y=M-1 -> Q=1.
4. WIDTH=8; X=200, Y=150, M=251; drive start again and change X to 5 at cycle 3 of CALC.
   - Second start ignored; Q=131; exactly one done pulse.
5. WIDTH=8; accept start, then rst=0 at cycle 4 of CALC.
   - Next edge: busy=0, ready=1, Q=0, done=0.
   - No done pulse for the aborted operation afterwards.
6. MODMUL_RANGE_CHECK_EN defined, WIDTH=8.
   - Y=251, M=251 -> done 1 cycle after acceptance, err=1, Q=0.
   - M=0 -> same.
   - Y=150, M=251, X=200 -> err=0, Q=131.
